// File: rtl/bram_pkg.sv
// Shared constants and helpers for the byte-lane block RAM.
package bram_pkg;

  localparam int BRAM_DATA_WIDTH = 32;
  localparam int BRAM_ADDR_WIDTH = 10;
  localparam int BYTE_W          = 8;

  // Number of byte lanes needed to cover a data word.
  function automatic int lane_count(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/bram_byte_lane.sv
// One 8-bit slice of the block RAM: own storage, own write enable, registered read.
// Read-during-write is read-first unless BRAM_WRITE_FIRST_EN is defined.
module bram_byte_lane
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [BYTE_W-1:0]     i_data,
  output logic [BYTE_W-1:0]     o_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Zero-filled at start; reset never touches the array so it stays a RAM primitive.
  logic [BYTE_W-1:0] mem [DEPTH] = '{default: '0};
  logic [BYTE_W-1:0] rd_data_p1;

  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_we) begin
      mem[i_addr] <= i_data;
    end
  end

  // Stage p1: registered read port
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_data_p1 <= '0;
    end else begin
`ifdef BRAM_WRITE_FIRST_EN
      rd_data_p1 <= i_we ? i_data : mem[i_addr];
`else
      rd_data_p1 <= mem[i_addr];
`endif
    end
  end

  assign o_data = rd_data_p1;

endmodule

// File: rtl/bram.sv
// Single-port byte-writable block RAM, one-cycle registered read, word addressed.
// Define BRAM_WRITE_FIRST_EN for write-first read-during-write (default read-first).
module bram
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH = BRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_write,
  input  logic [ADDR_WIDTH+1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [DATA_WIDTH/8-1:0] i_byte_write_enable,
  output logic [DATA_WIDTH-1:0]   o_data
);

  localparam int LANES = lane_count(DATA_WIDTH);

  if (DATA_WIDTH % BYTE_W != 0) begin : g_width_check
    $error("bram: DATA_WIDTH must be a multiple of 8");
  end

  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  unused_addr_hi;

  // The top two address bits alias onto the same word.
  assign word_addr      = i_addr[ADDR_WIDTH-1:0];
  assign unused_addr_hi = ^i_addr[ADDR_WIDTH+1:ADDR_WIDTH];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bram_byte_lane #(
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_lane (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_we   (i_write & i_byte_write_enable[k]),
      .i_addr (word_addr),
      .i_data (i_data[k*BYTE_W +: BYTE_W]),
      .o_data (o_data[k*BYTE_W +: BYTE_W])
    );
  end

endmodule

// File: tb/tb_bram.sv
// Self-checking bench for bram: scenario tasks with a queue of expected read words.
module tb_bram;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_write;
  logic [11:0] i_addr;
  logic [31:0] i_data;
  logic [3:0]  i_byte_write_enable;
  logic [31:0] o_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q [$];
  logic [31:0] exp;

  bram #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_write            (i_write),
    .i_addr             (i_addr),
    .i_data             (i_data),
    .i_byte_write_enable(i_byte_write_enable),
    .o_data             (o_data)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Drive one cycle of stimulus, let the DUT take the rising edge, then settle.
  task automatic drive(input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    @(negedge i_clk);
    i_write = w; i_addr = a; i_data = d; i_byte_write_enable = m;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    sb_q.push_back(32'h0);
    drive(1'b1, 12'd5, 32'hFFFF_FFFF, 4'hF);
    drive(1'b1, 12'd5, 32'hFFFF_FFFF, 4'hF);
    exp = sb_q.pop_front(); checks++;
    if (o_data !== exp) begin
      errors++; $display("FAIL reset_out: got %h expected %h", o_data, exp);
    end
    i_rst_n = 1'b1;
    sb_q.push_back(32'h0);
    drive(1'b0, 12'd5, 32'h0, 4'h0);
    exp = sb_q.pop_front(); checks++;
    if (o_data !== exp) begin
      errors++; $display("FAIL reset_write_suppressed: got %h expected %h", o_data, exp);
    end
  endtask

  task automatic test_single_write();
    drive(1'b1, 12'd0, 32'h0000_00AA, 4'hF);
    sb_q.push_back(32'h0000_00AA);
    drive(1'b0, 12'd0, 32'h0, 4'h0);
    exp = sb_q.pop_front(); checks++;
    if (o_data !== exp) begin
      errors++; $display("FAIL single_write: got %h expected %h", o_data, exp);
    end
  endtask

  task automatic test_multi_words();
    drive(1'b1, 12'd0, 32'h0000_00AA, 4'hF);
    drive(1'b1, 12'd1, 32'hAABB_CCDD, 4'hF);
    sb_q.push_back(32'h0000_00AA);
    drive(1'b0, 12'd0, 32'h0, 4'h0);
    exp = sb_q.pop_front(); checks++;
    if (o_data !== exp) begin
      errors++; $display("FAIL multi_word0: got %h expected %h", o_data, exp);
    end
    sb_q.push_back(32'hAABB_CCDD);
    drive(1'b0, 12'd1, 32'h0, 4'h0);
    exp = sb_q.pop_front(); checks++;
    if (o_data !== exp) begin
      errors++; $display("FAIL multi_word1: got %h expected %h", o_data, exp);
    end
  endtask

  task automatic test_loop();
    logic [11:0] a;
    for (int i = 0; i < 32; i++) begin
      a = 12'(2 * i + 1);
      drive(1'b1, a, 32'(i + 1), 4'hF);
    end
    // Read back through aliased addresses (upper two bits varied).
    for (int i = 0; i < 32; i++) begin
      a = 12'(2 * i + 1);
      a[11:10] = 2'(i % 4);
      sb_q.push_back(32'(i + 1));
      drive(1'b0, a, 32'h0, 4'(i));
      exp = sb_q.pop_front(); checks++;
      if (o_data !== exp) begin
        errors++; $display("FAIL loop_odd[%0d]: got %h expected %h", i, o_data, exp);
      end
    end
    // Even words between them were never written.
    for (int i = 1; i < 32; i++) begin
      sb_q.push_back(32'h0);
      drive(1'b0, 12'(2 * i), 32'h0, 4'h0);
      exp = sb_q.pop_front(); checks++;
      if (o_data !== exp) begin
        errors++; $display("FAIL loop_even[%0d]: got %h expected %h", i, o_data, exp);
      end
    end
  endtask

  task automatic test_byte_lanes();
    drive(1'b1, 12'd0, 32'h0000_0078, 4'b0001);
    drive(1'b1, 12'd0, 32'h0000_5600, 4'b0010);
    drive(1'b1, 12'd0, 32'h0034_0000, 4'b0100);
    drive(1'b1, 12'd0, 32'h1200_0000, 4'b1000);
    sb_q.push_back(32'h1234_5678);
    drive(1'b0, 12'd0, 32'h0, 4'h0);
    exp = sb_q.pop_front(); checks++;
    if (o_data !== exp) begin
      errors++; $display("FAIL byte_lanes: got %h expected %h", o_data, exp);
    end
  endtask

  task automatic test_halfwords();
    drive(1'b1, 12'd200, 32'hFFFF_CDEF, 4'b0011);
    drive(1'b1, 12'd200, 32'h89AB_FFFF, 4'b1100);
    sb_q.push_back(32'h89AB_CDEF);
    drive(1'b0, 12'd200, 32'h0, 4'h0);
    exp = sb_q.pop_front(); checks++;
    if (o_data !== exp) begin
      errors++; $display("FAIL halfwords: got %h expected %h", o_data, exp);
    end
    drive(1'b1, 12'd200, 32'hDEAD_BEEF, 4'b0000);
    sb_q.push_back(32'h89AB_CDEF);
    drive(1'b0, 12'd200, 32'h0, 4'h0);
    exp = sb_q.pop_front(); checks++;
    if (o_data !== exp) begin
      errors++; $display("FAIL zero_mask: got %h expected %h", o_data, exp);
    end
    sb_q.push_back(32'h89AB_CDEF);
    drive(1'b0, 12'd200, 32'h5555_5555, 4'b1010);
    exp = sb_q.pop_front(); checks++;
    if (o_data !== exp) begin
      errors++; $display("FAIL read_mask_ignored: got %h expected %h", o_data, exp);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 12'd300, 32'hCAFE_F00D, 4'hF);
    sb_q.push_back(32'hCAFE_F00D);
    drive(1'b0, 12'd300, 32'h0, 4'h0);
    exp = sb_q.pop_front(); checks++;
    if (o_data !== exp) begin
      errors++; $display("FAIL write_then_read: got %h expected %h", o_data, exp);
    end
    sb_q.push_back(32'h89AB_CDEF);
    drive(1'b0, 12'd200, 32'h0, 4'h0);
    exp = sb_q.pop_front(); checks++;
    if (o_data !== exp) begin
      errors++; $display("FAIL b2b_read200: got %h expected %h", o_data, exp);
    end
    sb_q.push_back(32'h1234_5678);
    drive(1'b0, 12'd0, 32'h0, 4'h0);
    exp = sb_q.pop_front(); checks++;
    if (o_data !== exp) begin
      errors++; $display("FAIL b2b_read0: got %h expected %h", o_data, exp);
    end
  endtask

  task automatic test_rdw_and_reset();
    drive(1'b1, 12'd100, 32'h1111_1111, 4'hF);
    i_rst_n = 1'b0;
    sb_q.push_back(32'h0);
    drive(1'b1, 12'd100, 32'h3333_3333, 4'hF);
    exp = sb_q.pop_front(); checks++;
    if (o_data !== exp) begin
      errors++; $display("FAIL rst_mid_out: got %h expected %h", o_data, exp);
    end
    i_rst_n = 1'b1;
    sb_q.push_back(32'h1111_1111);
    drive(1'b0, 12'd100, 32'h0, 4'h0);
    exp = sb_q.pop_front(); checks++;
    if (o_data !== exp) begin
      errors++; $display("FAIL rst_mem_kept: got %h expected %h", o_data, exp);
    end
`ifdef BRAM_WRITE_FIRST_EN
    sb_q.push_back(32'h2222_2222);
`else
    sb_q.push_back(32'h1111_1111);
`endif
    drive(1'b1, 12'd100, 32'h2222_2222, 4'hF);
    exp = sb_q.pop_front(); checks++;
    if (o_data !== exp) begin
      errors++; $display("FAIL read_during_write: got %h expected %h", o_data, exp);
    end
    sb_q.push_back(32'h2222_2222);
    drive(1'b0, 12'd100, 32'h0, 4'h0);
    exp = sb_q.pop_front(); checks++;
    if (o_data !== exp) begin
      errors++; $display("FAIL after_rdw: got %h expected %h", o_data, exp);
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_write = 1'b0;
    i_addr = '0;
    i_data = '0;
    i_byte_write_enable = '0;
    test_reset();
    test_single_write();
    test_multi_words();
    test_loop();
    test_byte_lanes();
    test_halfwords();
    test_back_to_back();
    test_rdw_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
